// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Purpose  : DEPTH back-to-back pipeline registers carrying valid, control,
//            NUM_DATA data words and a destination register address, with
//            stall (hold all stages), flush (bubble into stage 0), per-stage
//            forwarding taps and a saturating stalled-cycle counter.
// Ports    : clk_i, rst_ni (async, active low), stall_i, flush_i
//            valid_i/ctrl_i/data_i/rdaddr_i : entry into stage 0
//            valid_o/ctrl_o/data_o/rdaddr_o : contents of stage DEPTH-1
//            stage_wr_o  : per-stage valid & ctrl[0]
//            stage_rd_o  : per-stage rdaddr, stage s at [s*RD_W +: RD_W]
//            stall_cnt_o : saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int CTRL_W   = 2,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 2,
    parameter int RD_W     = 5,
    parameter int DEPTH    = 1,
    parameter int CNT_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0]   data_i,
    input  logic [RD_W-1:0]              rdaddr_i,
    output logic                         valid_o,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0]   data_o,
    output logic [RD_W-1:0]              rdaddr_o,
    output logic [DEPTH-1:0]             stage_wr_o,
    output logic [DEPTH*RD_W-1:0]        stage_rd_o,
    output logic [CNT_W-1:0]             stall_cnt_o
);

    localparam int c_DW = NUM_DATA * DATA_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    if ((DEPTH < 1) || (DEPTH > 4)) begin : g_depth_check
        $error("pipe_stage_chain: DEPTH must be in 1..4");
    end

    // Flattened view of every stage's registers, stage s in slice s.
    logic [DEPTH-1:0]        w_stg_valid;
    logic [DEPTH*CTRL_W-1:0] w_stg_ctrl;
    logic [DEPTH*c_DW-1:0]   w_stg_data;
    logic [DEPTH*RD_W-1:0]   w_stg_rd;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic              valid_d, valid_q;
        logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
        logic [c_DW-1:0]   data_d,  data_q;
        logic [RD_W-1:0]   rd_d,    rd_q;

        if (s == 0) begin : g_head
            // Flush beats stall here so a bubble can be injected while the
            // rest of the chain is frozen. ctrl is zeroed for invalid entries
            // so that a bubble can never assert RegWrite downstream.
            always_comb begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
                data_d  = data_q;
                rd_d    = rd_q;
                if (flush_i) begin
                    valid_d = 1'b0;
                    ctrl_d  = '0;
                    data_d  = '0;
                    rd_d    = '0;
                end else if (!stall_i) begin
                    valid_d = valid_i;
                    ctrl_d  = valid_i ? ctrl_i : '0;
                    data_d  = data_i;
                    rd_d    = rdaddr_i;
                end
            end
        end else begin : g_body
            always_comb begin
                valid_d = valid_q;
                ctrl_d  = ctrl_q;
                data_d  = data_q;
                rd_d    = rd_q;
                if (!stall_i) begin
                    valid_d = w_stg_valid[s-1];
                    ctrl_d  = w_stg_ctrl[(s-1)*CTRL_W +: CTRL_W];
                    data_d  = w_stg_data[(s-1)*c_DW +: c_DW];
                    rd_d    = w_stg_rd[(s-1)*RD_W +: RD_W];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
                data_q  <= '0;
                rd_q    <= '0;
            end else begin
                valid_q <= valid_d;
                ctrl_q  <= ctrl_d;
                data_q  <= data_d;
                rd_q    <= rd_d;
            end
        end

        assign w_stg_valid[s]                  = valid_q;
        assign w_stg_ctrl[s*CTRL_W +: CTRL_W]  = ctrl_q;
        assign w_stg_data[s*c_DW +: c_DW]      = data_q;
        assign w_stg_rd[s*RD_W +: RD_W]        = rd_q;
        assign stage_wr_o[s]                   = valid_q & ctrl_q[0];
    end

    assign valid_o    = w_stg_valid[DEPTH-1];
    assign ctrl_o     = w_stg_ctrl[(DEPTH-1)*CTRL_W +: CTRL_W];
    assign data_o     = w_stg_data[(DEPTH-1)*c_DW +: c_DW];
    assign rdaddr_o   = w_stg_rd[(DEPTH-1)*RD_W +: RD_W];
    assign stage_rd_o = w_stg_rd;

    // Stalled-cycle statistics, sticks at all-ones instead of wrapping.
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_i && (stall_cnt_q != c_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Purpose  : Self-checking bench for pipe_stage_chain. Four instances
//            (DEPTH 1..4, the DEPTH=1 one with a 4-bit counter) share one
//            stimulus stream and are each compared against a per-instance
//            behavioural model, plus a vector table and directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st, fl, vi;
    logic [1:0]  ci;
    logic [63:0] di;
    logic [4:0]  ri;

    logic        vo0, vo1, vo2, vo3;
    logic [1:0]  co0, co1, co2, co3;
    logic [63:0] do0, do1, do2, do3;
    logic [4:0]  ro0, ro1, ro2, ro3;
    logic [0:0]  sw0;
    logic [1:0]  sw1;
    logic [2:0]  sw2;
    logic [3:0]  sw3;
    logic [4:0]  sr0;
    logic [9:0]  sr1;
    logic [14:0] sr2;
    logic [19:0] sr3;
    logic [3:0]  cn0;
    logic [15:0] cn1, cn2, cn3;

    pipe_stage_chain #(.DEPTH(1), .CNT_W(4)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(st), .flush_i(fl), .valid_i(vi),
        .ctrl_i(ci), .data_i(di), .rdaddr_i(ri), .valid_o(vo0), .ctrl_o(co0),
        .data_o(do0), .rdaddr_o(ro0), .stage_wr_o(sw0), .stage_rd_o(sr0),
        .stall_cnt_o(cn0));
    pipe_stage_chain #(.DEPTH(2)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(st), .flush_i(fl), .valid_i(vi),
        .ctrl_i(ci), .data_i(di), .rdaddr_i(ri), .valid_o(vo1), .ctrl_o(co1),
        .data_o(do1), .rdaddr_o(ro1), .stage_wr_o(sw1), .stage_rd_o(sr1),
        .stall_cnt_o(cn1));
    pipe_stage_chain #(.DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(st), .flush_i(fl), .valid_i(vi),
        .ctrl_i(ci), .data_i(di), .rdaddr_i(ri), .valid_o(vo2), .ctrl_o(co2),
        .data_o(do2), .rdaddr_o(ro2), .stage_wr_o(sw2), .stage_rd_o(sr2),
        .stall_cnt_o(cn2));
    pipe_stage_chain #(.DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(st), .flush_i(fl), .valid_i(vi),
        .ctrl_i(ci), .data_i(di), .rdaddr_i(ri), .valid_o(vo3), .ctrl_o(co3),
        .data_o(do3), .rdaddr_o(ro3), .stage_wr_o(sw3), .stage_rd_o(sr3),
        .stall_cnt_o(cn3));

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [1:0]  c;
        logic [63:0] d;
        logic [4:0]  r;
    } ent_t;

    ent_t        m    [4][4];
    int unsigned mcnt [4];
    int unsigned cmax [4] = '{15, 65535, 65535, 65535};

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) m[i][s] = '0;
            mcnt[i] = 0;
        end
    endtask

    // One clock edge: an instruction moves one stage along unless frozen;
    // a flush always turns the entry slot into an empty bubble.
    task automatic model_step();
        ent_t nw;
        nw.v = vi;
        nw.c = vi ? ci : 2'b00;
        nw.d = di;
        nw.r = ri;
        if (fl) nw = '0;
        for (int i = 0; i < 4; i++) begin
            if (st) begin
                if (fl) m[i][0] = '0;
            end else begin
                for (int s = i; s > 0; s--) m[i][s] = m[i][s-1];
                m[i][0] = nw;
            end
            if (st && (mcnt[i] < cmax[i])) mcnt[i]++;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input string tag, input logic vo,
                              input logic [1:0] co, input logic [63:0] dd,
                              input logic [4:0] ro, input logic [3:0] sw,
                              input logic [19:0] sr, input logic [15:0] cn);
        ent_t        e;
        logic [3:0]  ew;
        logic [19:0] er;
        e  = m[i][i];
        ew = '0;
        er = '0;
        for (int s = 0; s <= i; s++) begin
            ew[s]        = m[i][s].v & m[i][s].c[0];
            er[s*5 +: 5] = m[i][s].r;
        end
        chk($sformatf("%s d%0d valid_o", tag, i+1),     64'(vo), 64'(e.v));
        chk($sformatf("%s d%0d ctrl_o", tag, i+1),      64'(co), 64'(e.c));
        chk($sformatf("%s d%0d data_o", tag, i+1),      dd,      e.d);
        chk($sformatf("%s d%0d rdaddr_o", tag, i+1),    64'(ro), 64'(e.r));
        chk($sformatf("%s d%0d stage_wr_o", tag, i+1),  64'(sw), 64'(ew));
        chk($sformatf("%s d%0d stage_rd_o", tag, i+1),  64'(sr), 64'(er));
        chk($sformatf("%s d%0d stall_cnt_o", tag, i+1), 64'(cn), 64'(mcnt[i]));
    endtask

    task automatic check_all(input string tag);
        check_inst(0, tag, vo0, co0, do0, ro0, {3'b0, sw0}, {15'b0, sr0}, {12'b0, cn0});
        check_inst(1, tag, vo1, co1, do1, ro1, {2'b0, sw1}, {10'b0, sr1}, cn1);
        check_inst(2, tag, vo2, co2, do2, ro2, {1'b0, sw2}, {5'b0, sr2},  cn2);
        check_inst(3, tag, vo3, co3, do3, ro3, sw3,         sr3,          cn3);
    endtask

    // Rising edge, model follows, then compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async rst d2 valid_o",     64'(vo1), 64'd0);
        chk("async rst d2 ctrl_o",      64'(co1), 64'd0);
        chk("async rst d2 data_o",      do1,      64'd0);
        chk("async rst d2 rdaddr_o",    64'(ro1), 64'd0);
        chk("async rst d2 stage_wr_o",  64'(sw1), 64'd0);
        chk("async rst d2 stage_rd_o",  64'(sr1), 64'd0);
        chk("async rst d2 stall_cnt_o", 64'(cn1), 64'd0);
        check_all("async rst");
        @(posedge clk);
        #1;
        check_all("rst held");
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic s, input logic f, input logic v,
                          input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
        st = s; fl = f; vi = v; ci = c; di = d; ri = r;
    endtask

    // ---------------- vector table (DEPTH=1 expectations) ----------------
    typedef struct {
        logic        st, fl, v;
        logic [1:0]  c;
        logic [63:0] d;
        logic [4:0]  r;
        logic        ev;
        logic [1:0]  ec;
        logic [63:0] ed;
        logic [4:0]  er;
        logic        ew;
        logic [3:0]  en;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b1, 2'b01, 64'hDEADBEEF_00001234, 5'd7,  1'b1, 2'b01, 64'hDEADBEEF_00001234, 5'd7,  1'b1, 4'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 2'b11, 64'h1111,              5'd3,  1'b0, 2'b00, 64'h1111,              5'd3,  1'b0, 4'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 2'b10, 64'h2222,              5'd9,  1'b1, 2'b10, 64'h2222,              5'd9,  1'b0, 4'd0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'b01, 64'h3333,              5'd4,  1'b1, 2'b10, 64'h2222,              5'd9,  1'b0, 4'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 2'b01, 64'h4444,              5'd5,  1'b0, 2'b00, 64'h0,                 5'd0,  1'b0, 4'd2};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'b11, 64'h5555,              5'd6,  1'b0, 2'b00, 64'h0,                 5'd0,  1'b0, 4'd2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 2'b11, 64'h6666,              5'd31, 1'b1, 2'b11, 64'h6666,              5'd31, 1'b1, 4'd2};

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 5'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2;
        rst_n = 1'b1;

        // Table
        for (int k = 0; k < 7; k++) begin
            set_in(tbl[k].st, tbl[k].fl, tbl[k].v, tbl[k].c, tbl[k].d, tbl[k].r);
            tick($sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d valid_o", k),     64'(vo0), 64'(tbl[k].ev));
            chk($sformatf("tbl%0d ctrl_o", k),      64'(co0), 64'(tbl[k].ec));
            chk($sformatf("tbl%0d data_o", k),      do0,      tbl[k].ed);
            chk($sformatf("tbl%0d rdaddr_o", k),    64'(ro0), 64'(tbl[k].er));
            chk($sformatf("tbl%0d stage_wr_o", k),  64'(sw0), 64'(tbl[k].ew));
            chk($sformatf("tbl%0d stall_cnt_o", k), 64'(cn0), 64'(tbl[k].en));
        end

        // Reset with full pipes (DEPTH=2 instance checked explicitly inside)
        do_reset();

        // Latency through DEPTH=3
        set_in(1'b0, 1'b0, 1'b1, 2'b01, 64'hDEADBEEF_00001234, 5'd7);
        tick("lat e1");
        chk("lat e1 d3 stage_wr_o", 64'(sw2), 64'b001);
        chk("lat e1 d3 valid_o",    64'(vo2), 64'd0);
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 5'd0);
        tick("lat e2");
        chk("lat e2 d3 stage_wr_o", 64'(sw2), 64'b010);
        tick("lat e3");
        chk("lat e3 d3 stage_wr_o", 64'(sw2), 64'b100);
        chk("lat e3 d3 valid_o",    64'(vo2), 64'd1);
        chk("lat e3 d3 ctrl_o",     64'(co2), 64'b01);
        chk("lat e3 d3 rdaddr_o",   64'(ro2), 64'd7);
        chk("lat e3 d3 data_o",     do2,      64'hDEADBEEF_00001234);

        // Stall hold on DEPTH=1
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 2'b01, 64'hAAAA_0000_AAAA_0001, 5'd10);
        tick("stall load");
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 1'b0, 1'b1, 2'b11, {$urandom, $urandom}, 5'(k + 20));
            tick("stall hold");
        end
        chk("stall d1 valid_o",     64'(vo0), 64'd1);
        chk("stall d1 rdaddr_o",    64'(ro0), 64'd10);
        chk("stall d1 data_o",      do0,      64'hAAAA_0000_AAAA_0001);
        chk("stall d1 stall_cnt_o", 64'(cn0), 64'd4);
        set_in(1'b0, 1'b0, 1'b1, 2'b10, 64'hBBBB_BBBB_0000_0002, 5'd11);
        tick("stall release");
        chk("release d1 rdaddr_o",  64'(ro0), 64'd11);
        chk("release d1 data_o",    do0,      64'hBBBB_BBBB_0000_0002);
        chk("release d1 ctrl_o",    64'(co0), 64'b10);

        // Flush + stall on DEPTH=2
        do_reset();
        set_in(1'b0, 1'b0, 1'b1, 2'b01, 64'hA, 5'd10);
        tick("fs A");
        set_in(1'b0, 1'b0, 1'b1, 2'b01, 64'hB, 5'd12);
        tick("fs B");
        chk("fs pre d2 stage_wr_o", 64'(sw1), 64'b11);
        set_in(1'b1, 1'b1, 1'b1, 2'b01, 64'hC, 5'd13);
        tick("fs edge");
        chk("fs d2 stage_wr_o", 64'(sw1), 64'b10);
        chk("fs d2 stage_rd_o", 64'(sr1), 64'({5'd10, 5'd0}));
        chk("fs d2 valid_o",    64'(vo1), 64'd1);
        chk("fs d2 rdaddr_o",   64'(ro1), 64'd10);

        // Bubbles with ctrl_i=11 never produce a write
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 2'b11, {$urandom, $urandom}, 5'($urandom));
            tick("bubble");
            if (k >= 4) begin
                chk("bubble stage_wr_o all", 64'({sw0, sw1, sw2, sw3}), 64'd0);
                chk("bubble d4 ctrl_o",      64'(co3), 64'd0);
            end
        end

        // Counter saturation
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            set_in(1'b1, 1'b0, 1'b1, 2'b01, 64'h0, 5'd1);
            tick("sat");
            if (k == 15) chk("sat d1 reaches 15", 64'(cn0), 64'd15);
        end
        chk("sat d1 stays 15", 64'(cn0), 64'd15);
        chk("sat d2 count 20", 64'(cn1), 64'd20);

        // Random traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
                   2'($urandom), {$urandom, $urandom}, 5'($urandom));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
